// File: rtl/pulse_stretch.sv
// Stretches single-cycle events into pulses with a minimum high time and a minimum low gap.
// Events that arrive mid-pulse are queued. Define PULSE_STRETCH_OVF_EN to get the sticky overflow flag.
module pulse_stretch #(
  parameter int HIGH_CYCLES_L2 = 10,
  parameter int GAP_CYCLES_L2  = 10,
  parameter int PEND_W         = 2
) (
  input  logic              i_clk,
  input  logic              i_rst_n,
  input  logic              i_pulse,
  output logic              o_dout,
  output logic              o_busy,
  output logic [PEND_W-1:0] o_pend,
  output logic              o_ovf,
  input  logic              i_ovf_clr
);
  localparam int CNT_W = (HIGH_CYCLES_L2 > GAP_CYCLES_L2) ? HIGH_CYCLES_L2 : GAP_CYCLES_L2;

  typedef enum logic [1:0] {IDLE, HIGH, GAP} state_t;

  state_t            state_q, state_nxt;
  logic [CNT_W-1:0]  cnt_q;
  logic [PEND_W-1:0] pend_q, pend_nxt;
  logic              dout_q, busy_q;
  logic              high_tc, gap_tc, sat;
  logic              take, direct, inc;

  assign high_tc = (state_q == HIGH) && (&cnt_q[HIGH_CYCLES_L2-1:0]);
  assign gap_tc  = (state_q == GAP)  && (&cnt_q[GAP_CYCLES_L2-1:0]);
  assign sat     = &pend_q;

  always_comb begin
    state_nxt = state_q;
    take      = 1'b0;
    direct    = 1'b0;
    case (state_q)
      IDLE: if (i_pulse) state_nxt = HIGH;
      HIGH: if (high_tc) state_nxt = GAP;
      GAP: begin
        if (gap_tc) begin
          if (pend_q != '0) begin
            state_nxt = HIGH;
            take      = 1'b1;
          end else if (i_pulse) begin
            // Event on the final gap cycle with nothing queued starts the next pulse directly.
            state_nxt = HIGH;
            direct    = 1'b1;
          end else begin
            state_nxt = IDLE;
          end
        end
      end
      default: state_nxt = IDLE;
    endcase

    inc      = i_pulse && (state_q != IDLE) && !direct;
    pend_nxt = pend_q;
    if (inc && !take && !sat)
      pend_nxt = pend_q + PEND_W'(1);
    else if (take && !inc)
      pend_nxt = pend_q - PEND_W'(1);
  end

  // Outputs come straight from flops loaded with the next-state decode, so they cannot glitch.
  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      state_q <= IDLE;
      cnt_q   <= '0;
      pend_q  <= '0;
      dout_q  <= 1'b0;
      busy_q  <= 1'b0;
    end else begin
      state_q <= state_nxt;
      cnt_q   <= (state_nxt != state_q) ? '0 : cnt_q + CNT_W'(1);
      pend_q  <= pend_nxt;
      dout_q  <= (state_nxt == HIGH);
      busy_q  <= (state_nxt != IDLE);
    end
  end

  assign o_dout = dout_q;
  assign o_busy = busy_q;
  assign o_pend = pend_q;

`ifdef PULSE_STRETCH_OVF_EN
  logic ovf_q, drop;

  assign drop = inc && !take && sat;

  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n)       ovf_q <= 1'b0;
    else if (i_ovf_clr) ovf_q <= 1'b0;
    else if (drop)      ovf_q <= 1'b1;
  end

  assign o_ovf = ovf_q;
`else
  logic unused_ovf_clr;

  assign unused_ovf_clr = i_ovf_clr;
  assign o_ovf          = 1'b0;
`endif

endmodule

// File: tb/tb_pulse_stretch.sv
// Scoreboard bench for pulse_stretch with 4-cycle high, 4-cycle gap and a 2-bit pending counter.
// Each entry holds the expected {dout, busy, pend, ovf} for one numbered cycle.
module tb_pulse_stretch;
  logic       i_clk = 1'b0;
  logic       i_rst_n = 1'b0;
  logic       i_pulse = 1'b0;
  logic       i_ovf_clr = 1'b0;
  logic       o_dout, o_busy, o_ovf;
  logic [1:0] o_pend;

  typedef struct {
    int         cyc;
    logic [4:0] v;
  } exp_t;

  exp_t exp_q[$];
  exp_t e;
  int   cyc;
  int   nchk = 0;
  int   npass = 0;

  pulse_stretch #(.HIGH_CYCLES_L2(2), .GAP_CYCLES_L2(2), .PEND_W(2)) dut (
    .i_clk(i_clk), .i_rst_n(i_rst_n), .i_pulse(i_pulse), .o_dout(o_dout),
    .o_busy(o_busy), .o_pend(o_pend), .o_ovf(o_ovf), .i_ovf_clr(i_ovf_clr)
  );

  always #5 i_clk = ~i_clk;

`ifdef PULSE_STRETCH_OVF_EN
  localparam bit OVF_EN = 1'b1;
`else
  localparam bit OVF_EN = 1'b0;
`endif

  // Leaves the bench at 1 time unit after a rising edge, with cycle number 0.
  task automatic apply_reset();
    i_pulse   = 1'b0;
    i_ovf_clr = 1'b0;
    i_rst_n   = 1'b0;
    repeat (3) @(posedge i_clk);
    @(negedge i_clk);
    i_rst_n = 1'b1;
    @(posedge i_clk);
    #1;
    cyc = 0;
    exp_q.delete();
  endtask

  task automatic test_reset();
    i_rst_n = 1'b0;
    #2;
    nchk++;
    if ({o_dout, o_busy, o_pend, o_ovf} !== 5'b0)
      $display("FAIL reset_async got=%b exp=%b", {o_dout, o_busy, o_pend, o_ovf}, 5'b0);
    else npass++;
    apply_reset();
    for (int c = 0; c <= 3; c++) exp_q.push_back('{c, 5'b0});
    while (cyc <= 3) begin
      @(negedge i_clk);
      while (exp_q.size() > 0 && exp_q[0].cyc == cyc) begin
        e = exp_q.pop_front();
        nchk++;
        if ({o_dout, o_busy, o_pend, o_ovf} !== e.v)
          $display("FAIL reset_idle cyc=%0d got=%b exp=%b", cyc, {o_dout, o_busy, o_pend, o_ovf}, e.v);
        else npass++;
      end
      @(posedge i_clk); #1 cyc++;
    end
  endtask

  task automatic test_single();
    apply_reset();
    for (int c = 9; c <= 21; c++)
      exp_q.push_back('{c, {c >= 11 && c <= 14, c >= 11 && c <= 18, 2'd0, 1'b0}});
    while (cyc <= 21) begin
      i_pulse = (cyc == 10);
      @(negedge i_clk);
      while (exp_q.size() > 0 && exp_q[0].cyc == cyc) begin
        e = exp_q.pop_front();
        nchk++;
        if ({o_dout, o_busy, o_pend, o_ovf} !== e.v)
          $display("FAIL single cyc=%0d got=%b exp=%b", cyc, {o_dout, o_busy, o_pend, o_ovf}, e.v);
        else npass++;
      end
      @(posedge i_clk); #1 cyc++;
    end
    i_pulse = 1'b0;
  endtask

  task automatic test_queue();
    logic [1:0] p;
    apply_reset();
    for (int c = 10; c <= 36; c++) begin
      p = (c == 13) ? 2'd1 : (c >= 14 && c <= 18) ? 2'd2 : (c >= 19 && c <= 26) ? 2'd1 : 2'd0;
      exp_q.push_back('{c, {(c >= 11 && c <= 14) || (c >= 19 && c <= 22) || (c >= 27 && c <= 30),
                            c >= 11 && c <= 34, p, 1'b0}});
    end
    while (cyc <= 36) begin
      i_pulse = (cyc == 10 || cyc == 12 || cyc == 13);
      @(negedge i_clk);
      while (exp_q.size() > 0 && exp_q[0].cyc == cyc) begin
        e = exp_q.pop_front();
        nchk++;
        if ({o_dout, o_busy, o_pend, o_ovf} !== e.v)
          $display("FAIL queue cyc=%0d got=%b exp=%b", cyc, {o_dout, o_busy, o_pend, o_ovf}, e.v);
        else npass++;
      end
      @(posedge i_clk); #1 cyc++;
    end
    i_pulse = 1'b0;
  endtask

  task automatic test_saturate();
    logic [1:0] p;
    logic       ov;
    apply_reset();
    for (int c = 10; c <= 45; c++) begin
      p  = (c == 12) ? 2'd1 : (c == 13) ? 2'd2 : (c >= 14 && c <= 18) ? 2'd3 :
           (c >= 19 && c <= 26) ? 2'd2 : (c >= 27 && c <= 34) ? 2'd1 : 2'd0;
      ov = OVF_EN && c >= 15 && c <= 40;
      exp_q.push_back('{c, {(c >= 11 && c <= 14) || (c >= 19 && c <= 22) ||
                            (c >= 27 && c <= 30) || (c >= 35 && c <= 38),
                            c >= 11 && c <= 42, p, ov}});
    end
    while (cyc <= 45) begin
      i_pulse   = (cyc >= 10 && cyc <= 16);
      i_ovf_clr = (cyc == 40);
      @(negedge i_clk);
      while (exp_q.size() > 0 && exp_q[0].cyc == cyc) begin
        e = exp_q.pop_front();
        nchk++;
        if ({o_dout, o_busy, o_pend, o_ovf} !== e.v)
          $display("FAIL saturate cyc=%0d got=%b exp=%b", cyc, {o_dout, o_busy, o_pend, o_ovf}, e.v);
        else npass++;
      end
      @(posedge i_clk); #1 cyc++;
    end
    i_pulse   = 1'b0;
    i_ovf_clr = 1'b0;
  endtask

  task automatic test_gap_terminal();
    apply_reset();
    for (int c = 10; c <= 36; c++)
      exp_q.push_back('{c, {(c >= 11 && c <= 14) || (c >= 19 && c <= 22) || (c >= 27 && c <= 30),
                            c >= 11 && c <= 34, (c >= 13 && c <= 26) ? 2'd1 : 2'd0, 1'b0}});
    while (cyc <= 36) begin
      i_pulse = (cyc == 10 || cyc == 12 || cyc == 18);
      @(negedge i_clk);
      while (exp_q.size() > 0 && exp_q[0].cyc == cyc) begin
        e = exp_q.pop_front();
        nchk++;
        if ({o_dout, o_busy, o_pend, o_ovf} !== e.v)
          $display("FAIL gap_terminal cyc=%0d got=%b exp=%b", cyc, {o_dout, o_busy, o_pend, o_ovf}, e.v);
        else npass++;
      end
      @(posedge i_clk); #1 cyc++;
    end
    i_pulse = 1'b0;
  endtask

  task automatic test_mid_reset();
    apply_reset();
    for (int c = 10; c <= 26; c++)
      exp_q.push_back('{c, {c == 11 || (c >= 21 && c <= 24), c == 11 || c >= 21, 2'd0, 1'b0}});
    while (cyc <= 26) begin
      i_pulse = (cyc == 10 || cyc == 20);
      if (cyc == 12) begin
        i_rst_n = 1'b0;
        #1;
        nchk++;
        if ({o_dout, o_busy, o_pend} !== 4'b0)
          $display("FAIL mid_reset_async got=%b exp=%b", {o_dout, o_busy, o_pend}, 4'b0);
        else npass++;
      end
      if (cyc == 15) i_rst_n = 1'b1;
      @(negedge i_clk);
      while (exp_q.size() > 0 && exp_q[0].cyc == cyc) begin
        e = exp_q.pop_front();
        nchk++;
        if ({o_dout, o_busy, o_pend, o_ovf} !== e.v)
          $display("FAIL mid_reset cyc=%0d got=%b exp=%b", cyc, {o_dout, o_busy, o_pend, o_ovf}, e.v);
        else npass++;
      end
      @(posedge i_clk); #1 cyc++;
    end
    i_pulse = 1'b0;
    i_rst_n = 1'b1;
  endtask

  task automatic test_back_to_back();
    apply_reset();
    for (int c = 10; c <= 40; c++)
      exp_q.push_back('{c, {(c >= 11 && c <= 14) || (c >= 31 && c <= 34),
                            (c >= 11 && c <= 18) || (c >= 31 && c <= 38), 2'd0, 1'b0}});
    while (cyc <= 40) begin
      i_pulse = (cyc == 10 || cyc == 30);
      @(negedge i_clk);
      while (exp_q.size() > 0 && exp_q[0].cyc == cyc) begin
        e = exp_q.pop_front();
        nchk++;
        if ({o_dout, o_busy, o_pend, o_ovf} !== e.v)
          $display("FAIL back_to_back cyc=%0d got=%b exp=%b", cyc, {o_dout, o_busy, o_pend, o_ovf}, e.v);
        else npass++;
      end
      @(posedge i_clk); #1 cyc++;
    end
    i_pulse = 1'b0;
  endtask

  initial begin
    test_reset();
    test_single();
    test_queue();
    test_saturate();
    test_gap_terminal();
    test_mid_reset();
    test_back_to_back();
    $display("%0d/%0d checks passed", npass, nchk);
    $finish;
  end

  initial begin
    #100000;
    $display("FAIL timeout got=running exp=finished");
    $fatal(1, "timeout");
  end
endmodule
